i2s_tx_24: RTL and testbench

Downstream stage of the 31-to-24-bit sample converter in the additive-synth output path. Accepts 24-bit stereo sample pairs over an AXI-Stream-style valid/ready port and serialises them as a standard I2S stream (BCLK, LRCK, SDATA) for the audio DAC. Runs entirely in the converter's clock domain and derives BCLK by integer division. Provides one frame of buffering and reports sample underruns.

---
 rtl/i2s_tx_24.sv | 167 ++++++++++++++++
 tb/tb_i2s_tx_24.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_tx_24.sv
`default_nettype none
// ============================================================================
//  Module      : i2s_tx_24
//  Description : I2S transmitter for 24-bit stereo pairs. Accepts one pair per
//                frame over a valid/ready port into a single holding register,
//                divides ACLK down to BCLK and shifts the words out MSB first
//                with the standard one-BCLK delay after the LRCK edge. Flags a
//                sticky underrun when a frame starts with no pair waiting.
//  Revision    : 1.0 - initial release
// ============================================================================
module i2s_tx_24 #(
  parameter int DATA_W   = 24,
  parameter int SLOT_W   = 32,
  parameter int BCLK_DIV = 4
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic [2*DATA_W-1:0]   s_tdata,
  input  logic                  s_tvalid,
  output logic                  s_tready,
  output logic                  i2s_bclk,
  output logic                  i2s_lrck,
  output logic                  i2s_sdata,
  output logic                  frame_start,
  output logic                  underrun,
  input  logic                  underrun_clr
);

  localparam int c_DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam int c_BIT_W = $clog2(2 * SLOT_W);

  localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(BCLK_DIV - 1);
  localparam logic [c_DIV_W-1:0] c_DIV_ONE  = c_DIV_W'(1);
  localparam logic [c_BIT_W-1:0] c_BIT_LAST = c_BIT_W'(2 * SLOT_W - 1);
  localparam logic [c_BIT_W-1:0] c_BIT_ONE  = c_BIT_W'(1);
  localparam logic [c_BIT_W-1:0] c_SLOT     = c_BIT_W'(SLOT_W);
  localparam logic [c_BIT_W-1:0] c_DATA     = c_BIT_W'(DATA_W);

  // Registered state
  logic [c_DIV_W-1:0]  r_div_cnt;
  logic [c_BIT_W-1:0]  r_bit_cnt;
  logic [2*DATA_W-1:0] r_nxt;
  logic                r_nxt_full;
  logic [2*DATA_W-1:0] r_cur;
  logic                r_armed;

  // Combinational helpers
  logic                w_tc;
  logic                w_fall_tick;
  logic                w_load;
  logic                w_handshake;
  logic                w_underrun_set;
  logic [c_BIT_W-1:0]  w_bit_nxt;
  logic                w_right;
  logic [c_BIT_W-1:0]  w_slot_bit;
  logic [DATA_W-1:0]   w_word;
  logic [DATA_W-1:0]   w_shift;
  logic                w_in_data;
  logic                w_sdata_nxt;

  // Ready only reflects the holding register; held low while in reset so no
  // pair can slip in during the reset window.
  assign s_tready    = ~r_nxt_full & ~ARESET;
  assign w_handshake = s_tvalid & s_tready;

  // Divider terminal count; a terminal count with BCLK high is a falling edge.
  assign w_tc        = (r_div_cnt == c_DIV_LAST);
  assign w_fall_tick = w_tc & i2s_bclk;
  assign w_load      = w_fall_tick & (r_bit_cnt == c_BIT_LAST);

  // A frame starting empty only counts as an underrun once data has flowed.
  assign w_underrun_set = w_load & ~r_nxt_full & r_armed;

  // Bit position that the coming falling edge moves to, and the data bit for it.
  always_comb begin
    w_bit_nxt   = (r_bit_cnt == c_BIT_LAST) ? '0 : r_bit_cnt + c_BIT_ONE;
    w_right     = (w_bit_nxt >= c_SLOT);
    w_slot_bit  = w_right ? (w_bit_nxt - c_SLOT) : w_bit_nxt;
    w_word      = w_right ? r_cur[DATA_W-1:0] : r_cur[2*DATA_W-1:DATA_W];
    // Slot bit 0 is the I2S delay bit; bits 1..DATA_W carry the word MSB first.
    w_in_data   = (w_slot_bit != '0) && (w_slot_bit <= c_DATA);
    w_shift     = w_word << (w_slot_bit - c_BIT_ONE);
    w_sdata_nxt = w_in_data & w_shift[DATA_W-1];
  end

  // ACLK divider producing the BCLK half-period tick.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_div_cnt <= '0;
    end else if (w_tc) begin
      r_div_cnt <= '0;
    end else begin
      r_div_cnt <= r_div_cnt + c_DIV_ONE;
    end
  end

  // BCLK toggles on every divider terminal count.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      i2s_bclk <= 1'b0;
    end else if (w_tc) begin
      i2s_bclk <= ~i2s_bclk;
    end
  end

  // Bit counter starts at the last bit so the first falling edge opens a frame.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_bit_cnt <= c_BIT_LAST;
    end else if (w_fall_tick) begin
      r_bit_cnt <= w_bit_nxt;
    end
  end

  // Holding register and frame register; a same-cycle handshake on an empty
  // load is kept for the following frame rather than bypassed.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_nxt      <= '0;
      r_nxt_full <= 1'b0;
      r_cur      <= '0;
      r_armed    <= 1'b0;
    end else begin
      if (w_load) begin
        if (r_nxt_full) begin
          r_cur      <= r_nxt;
          r_nxt_full <= 1'b0;
          r_armed    <= 1'b1;
        end else begin
          r_cur <= '0;
        end
      end
      if (w_handshake) begin
        r_nxt      <= s_tdata;
        r_nxt_full <= 1'b1;
      end
    end
  end

  // Serial outputs change together with the falling BCLK edge.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      i2s_lrck    <= 1'b0;
      i2s_sdata   <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= w_load;
      if (w_fall_tick) begin
        i2s_lrck  <= w_right;
        i2s_sdata <= w_sdata_nxt;
      end
    end
  end

  // Sticky underrun flag; a new underrun beats a simultaneous clear.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      underrun <= 1'b0;
    end else if (w_underrun_set) begin
      underrun <= 1'b1;
    end else if (underrun_clr) begin
      underrun <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_i2s_tx_24.sv
`default_nettype none
// ============================================================================
//  Module      : tb_i2s_tx_24
//  Description : Self-checking bench for i2s_tx_24 with a frame-level model
//                derived from edge counts since reset release.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_i2s_tx_24;

  localparam int DATA_W   = 24;
  localparam int SLOT_W   = 32;
  localparam int BCLK_DIV = 4;
  localparam int BPER     = 2 * BCLK_DIV;          // ACLK cycles per BCLK
  localparam int FRAME    = 2 * SLOT_W * BPER;     // ACLK cycles per frame

  logic                ACLK = 1'b0;
  logic                ARESET = 1'b1;
  logic [2*DATA_W-1:0] s_tdata = '0;
  logic                s_tvalid = 1'b0;
  logic                underrun_clr = 1'b0;
  logic                s_tready, i2s_bclk, i2s_lrck, i2s_sdata, frame_start, underrun;

  int checks = 0;
  int failures = 0;

  // Model state: edges since reset release, pending pair, frame word, flags.
  int          n = 0;
  logic        pend = 1'b0;
  logic [47:0] pend_d = '0;
  logic [47:0] cur_w = '0;
  logic        armed = 1'b0;
  logic        m_und = 1'b0;
  logic        m_fs = 1'b0;

  // Words recovered from the serial line, one entry per frame.
  logic [47:0] rx [0:15];

  i2s_tx_24 #(.DATA_W(DATA_W), .SLOT_W(SLOT_W), .BCLK_DIV(BCLK_DIV)) dut (
    .ACLK(ACLK), .ARESET(ARESET), .s_tdata(s_tdata), .s_tvalid(s_tvalid),
    .s_tready(s_tready), .i2s_bclk(i2s_bclk), .i2s_lrck(i2s_lrck),
    .i2s_sdata(i2s_sdata), .frame_start(frame_start), .underrun(underrun),
    .underrun_clr(underrun_clr)
  );

  always #5 ACLK = ~ACLK;

  // Frames open on the first BCLK fall and then every FRAME cycles.
  function automatic logic is_load(input int e);
    return (e >= BPER) && (((e - BPER) % FRAME) == 0);
  endfunction

  // Frame-level behavioural model.
  always @(posedge ACLK) begin
    if (ARESET) begin
      n <= 0; pend <= 1'b0; armed <= 1'b0; m_und <= 1'b0; cur_w <= '0; m_fs <= 1'b0;
    end else begin
      n    <= n + 1;
      m_fs <= is_load(n + 1);
      if (is_load(n + 1)) begin
        if (pend) begin cur_w <= pend_d; armed <= 1'b1; end
        else cur_w <= '0;
      end
      if (is_load(n + 1) && !pend && armed) m_und <= 1'b1;
      else if (underrun_clr) m_und <= 1'b0;
      if (s_tvalid && !pend) begin pend <= 1'b1; pend_d <= s_tdata; end
      else if (is_load(n + 1)) pend <= 1'b0;
    end
  end

  // Expected {bclk, lrck, sdata, frame_start, s_tready, underrun} right now.
  function automatic logic [5:0] exp_vec();
    logic bc, lr, sd;
    int k, b, s;
    logic [23:0] w, t;
    bc = ((n / BCLK_DIV) % 2) == 1;
    lr = 1'b0; sd = 1'b0;
    if (n >= BPER) begin
      k  = (n - BPER) / BPER;
      b  = k % (2 * SLOT_W);
      lr = (b >= SLOT_W);
      s  = b % SLOT_W;
      w  = lr ? cur_w[23:0] : cur_w[47:24];
      t  = w >> (DATA_W - s);
      if (s >= 1 && s <= DATA_W) sd = t[0];
    end
    return {bc, lr, sd, m_fs, (!ARESET && !pend), m_und};
  endfunction

  // Receiver: BCLK rises BCLK_DIV cycles after each fall.
  function automatic int rx_b(input int e);
    return ((e - BPER - BCLK_DIV) / BPER) % (2 * SLOT_W);
  endfunction
  function automatic int rx_f(input int e);
    return ((e - BPER - BCLK_DIV) / BPER) / (2 * SLOT_W);
  endfunction
  function automatic int rx_pos(input int e);
    return ((rx_b(e) >= SLOT_W) ? 0 : DATA_W) + DATA_W - (rx_b(e) % SLOT_W);
  endfunction

  always @(negedge ACLK) begin
    if (n == 0) begin
      for (int i = 0; i < 16; i++) rx[i] <= '0;
    end else if (n >= BPER + BCLK_DIV && ((n - BPER - BCLK_DIV) % BPER) == 0 &&
                 rx_f(n) < 16 && (rx_b(n) % SLOT_W) >= 1 && (rx_b(n) % SLOT_W) <= DATA_W) begin
      rx[rx_f(n)][rx_pos(n)] <= i2s_sdata;
    end
  end

  task automatic do_reset();
    ARESET = 1'b1; s_tvalid = 1'b0; underrun_clr = 1'b0;
    repeat (3) @(negedge ACLK);
    ARESET = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    ARESET = 1'b1; s_tvalid = 1'b1; s_tdata = {24'($urandom), 24'($urandom)};
    repeat (10) begin
      @(negedge ACLK);
      checks++;
      if ({i2s_bclk, i2s_lrck, i2s_sdata, frame_start, underrun, s_tready} !== 6'b0) begin
        failures++;
        $display("FAIL reset_outputs got=%b exp=000000",
                 {i2s_bclk, i2s_lrck, i2s_sdata, frame_start, underrun, s_tready});
      end
    end
    s_tvalid = 1'b0; ARESET = 1'b0;
    #1;
    checks++;
    if (s_tready !== 1'b1) begin
      failures++; $display("FAIL reset_release_ready got=%b exp=1", s_tready);
    end
  endtask

  task automatic test_single_frame();
    logic hs;
    int fs_cnt;
    fs_cnt = 0;
    do_reset();
    s_tdata = 48'hA5A5A5_5A5A5A; s_tvalid = 1'b1;
    repeat (2 * FRAME + 16) begin
      hs = s_tvalid && s_tready;
      @(negedge ACLK);
      if (hs) s_tvalid = 1'b0;
      checks++;
      if ({i2s_bclk, i2s_lrck, i2s_sdata, frame_start, s_tready, underrun} !== exp_vec()) begin
        failures++;
        $display("FAIL single_frame_outputs n=%0d got=%b exp=%b", n,
                 {i2s_bclk, i2s_lrck, i2s_sdata, frame_start, s_tready, underrun}, exp_vec());
      end
      fs_cnt += int'(frame_start);
    end
    checks++;
    if (fs_cnt !== 3) begin failures++; $display("FAIL single_frame_fs_count got=%0d exp=3", fs_cnt); end
    checks++;
    if (rx[0] !== 48'hA5A5A5_5A5A5A) begin
      failures++; $display("FAIL single_frame_word got=%h exp=a5a5a55a5a5a", rx[0]);
    end
    checks++;
    if (rx[1] !== 48'h0) begin failures++; $display("FAIL single_frame_empty got=%h exp=0", rx[1]); end
  endtask

  task automatic test_backpressure();
    logic [47:0] p [0:2];
    int acc [0:2];
    int idx;
    logic hs;
    idx = 0;
    for (int i = 0; i < 3; i++) begin p[i] = {24'($urandom), 24'($urandom)}; acc[i] = -1; end
    do_reset();
    s_tdata = p[0]; s_tvalid = 1'b1;
    repeat (3 * FRAME + 40) begin
      hs = s_tvalid && s_tready;
      @(negedge ACLK);
      if (hs) begin
        acc[idx] = n; idx++;
        if (idx < 3) s_tdata = p[idx]; else s_tvalid = 1'b0;
      end
      checks++;
      if ({i2s_bclk, i2s_lrck, i2s_sdata, frame_start, s_tready, underrun} !== exp_vec()) begin
        failures++;
        $display("FAIL backpressure_outputs n=%0d got=%b exp=%b", n,
                 {i2s_bclk, i2s_lrck, i2s_sdata, frame_start, s_tready, underrun}, exp_vec());
      end
    end
    checks++;
    if (acc[0] !== 1 || acc[1] !== BPER + 1 || acc[2] !== BPER + FRAME + 1) begin
      failures++;
      $display("FAIL backpressure_accept_edges got=%0d,%0d,%0d exp=1,%0d,%0d",
               acc[0], acc[1], acc[2], BPER + 1, BPER + FRAME + 1);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (rx[i] !== p[i]) begin
        failures++; $display("FAIL backpressure_order frame=%0d got=%h exp=%h", i, rx[i], p[i]);
      end
    end
  endtask

  task automatic test_underrun();
    logic [47:0] p;
    logic hs;
    p = {24'($urandom), 24'($urandom)};
    do_reset();
    s_tdata = p; s_tvalid = 1'b1;
    while (n < FRAME + 80) begin
      hs = s_tvalid && s_tready;
      @(negedge ACLK);
      if (hs) s_tvalid = 1'b0;
      checks++;
      if ({i2s_sdata, underrun} !== {exp_vec()[3], exp_vec()[0]}) begin
        failures++;
        $display("FAIL underrun_track n=%0d got=%b%b exp=%b%b", n, i2s_sdata, underrun,
                 exp_vec()[3], exp_vec()[0]);
      end
    end
    checks++;
    if (underrun !== 1'b1) begin failures++; $display("FAIL underrun_set got=%b exp=1", underrun); end
    checks++;
    if (rx[0] !== p) begin failures++; $display("FAIL underrun_first_frame got=%h exp=%h", rx[0], p); end
    underrun_clr = 1'b1;
    @(negedge ACLK);
    underrun_clr = 1'b0;
    checks++;
    if (underrun !== 1'b0) begin failures++; $display("FAIL underrun_clear got=%b exp=0", underrun); end
    while (n < BPER + 2 * FRAME - 1) @(negedge ACLK);
    underrun_clr = 1'b1;
    @(negedge ACLK);
    underrun_clr = 1'b0;
    checks++;
    if ({frame_start, underrun} !== 2'b11) begin
      failures++; $display("FAIL underrun_set_beats_clear got=%b exp=11", {frame_start, underrun});
    end
    checks++;
    if (rx[1] !== 48'h0) begin failures++; $display("FAIL underrun_zero_frame got=%h exp=0", rx[1]); end
  endtask

  task automatic test_startup();
    int fs_cnt;
    int bad;
    fs_cnt = 0; bad = 0;
    do_reset();
    while (n < 3 * FRAME + 16) begin
      @(negedge ACLK);
      fs_cnt += int'(frame_start);
      if (i2s_sdata !== 1'b0 || underrun !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0) begin failures++; $display("FAIL startup_quiet bad_cycles got=%0d exp=0", bad); end
    checks++;
    if (fs_cnt !== 4) begin failures++; $display("FAIL startup_fs_count got=%0d exp=4", fs_cnt); end
  endtask

  task automatic test_mid_reset();
    logic hs;
    int bad;
    bad = 0;
    do_reset();
    s_tdata = {24'($urandom), 24'($urandom)}; s_tvalid = 1'b1;
    while (n < BPER + 40 * BPER) begin
      hs = s_tvalid && s_tready;
      @(negedge ACLK);
      if (hs) begin
        if (n == 1) s_tdata = {24'($urandom), 24'($urandom)};
        else s_tvalid = 1'b0;
      end
    end
    checks++;
    if (s_tready !== 1'b0) begin failures++; $display("FAIL mid_reset_pending got=%b exp=0", s_tready); end
    ARESET = 1'b1;
    @(negedge ACLK);
    checks++;
    if ({i2s_bclk, i2s_lrck, i2s_sdata, frame_start, underrun, s_tready} !== 6'b0) begin
      failures++;
      $display("FAIL mid_reset_outputs got=%b exp=000000",
               {i2s_bclk, i2s_lrck, i2s_sdata, frame_start, underrun, s_tready});
    end
    repeat (2) @(negedge ACLK);
    ARESET = 1'b0; s_tvalid = 1'b0;
    #1;
    while (n < 2 * FRAME + 16) begin
      @(negedge ACLK);
      if (i2s_sdata !== 1'b0 || underrun !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0) begin failures++; $display("FAIL mid_reset_flushed bad_cycles got=%0d exp=0", bad); end
  endtask

  task automatic test_random();
    logic hs;
    do_reset();
    repeat (6 * FRAME) begin
      hs = s_tvalid && s_tready;
      @(negedge ACLK);
      checks++;
      if ({i2s_bclk, i2s_lrck, i2s_sdata, frame_start, s_tready, underrun} !== exp_vec()) begin
        failures++;
        $display("FAIL random_outputs n=%0d got=%b exp=%b", n,
                 {i2s_bclk, i2s_lrck, i2s_sdata, frame_start, s_tready, underrun}, exp_vec());
      end
      if (hs || !s_tvalid) begin
        s_tvalid = ($urandom_range(0, 299) == 0);
        s_tdata  = {24'($urandom), 24'($urandom)};
      end
      underrun_clr = ($urandom_range(0, 199) == 0);
    end
    underrun_clr = 1'b0; s_tvalid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_frame();
    test_backpressure();
    test_underrun();
    test_startup();
    test_mid_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
